// File: rtl/player_pkg.sv
//------------------------------------------------------------------------------
// Module   : player_pkg
// Purpose  : Shared types, constants and 7-segment lookup for pattern_player.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package player_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    localparam logic [6:0] HEX_BLANK = 7'h7F;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7_lut(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
//------------------------------------------------------------------------------
// Module   : rise_detect
// Purpose  : One-cycle pulse on each rising edge of a synchronous level.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pattern_player.sv
//------------------------------------------------------------------------------
// Module   : pattern_player
// Purpose  : Tick-driven LED pattern sequencer with LOOP/PINGPONG/ONESHOT/HOLD
//            playback over a latency-ROM. Optional macro PLAYER_HEX_EN enables
//            the 7-segment display of seq_num on hex1/hex0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pattern_player #(
    parameter int NUM_SEQ  = 64,
    parameter int NUM_STEP = 16,
    parameter int LED_W    = 10,
    parameter int ROM_LAT  = 1,
    localparam int SEQ_W   = (NUM_SEQ  > 1) ? $clog2(NUM_SEQ)  : 1,
    localparam int STEP_W  = (NUM_STEP > 1) ? $clog2(NUM_STEP) : 1
) (
    input  logic                    CLK_50,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    pb_seq_up,
    input  logic                    pb_seq_dn,
    input  logic [1:0]              mode,
    input  logic                    pause,
    output logic [SEQ_W+STEP_W-1:0] rom_addr,
    input  logic [LED_W-1:0]        rom_data,
    output logic [LED_W-1:0]        led,
    output logic [SEQ_W-1:0]        seq_num,
    output logic [STEP_W-1:0]       step,
    output logic                    done,
    output logic [6:0]              hex1,
    output logic [6:0]              hex0
);

    import player_pkg::*;

    localparam logic [SEQ_W-1:0]  c_seq_last  = SEQ_W'(NUM_SEQ - 1);
    localparam logic [STEP_W-1:0] c_step_last = STEP_W'(NUM_STEP - 1);
    localparam logic [STEP_W-1:0] c_step_pen  = STEP_W'((NUM_STEP > 1) ? NUM_STEP - 2 : 0);

    logic                w_up_rise;
    logic                w_dn_rise;
    mode_e               w_mode;
    logic [SEQ_W-1:0]    w_seq_nxt;
    logic [STEP_W-1:0]   w_step_nxt;
    logic                w_dir_nxt;
    logic                w_done_nxt;
    logic                w_upd;

    logic [SEQ_W-1:0]    r_seq;
    logic [STEP_W-1:0]   r_step;
    logic                r_dir_back;
    logic                r_done;
    mode_e               r_mode_prev;
    logic [ROM_LAT-1:0]  r_upd_pipe;
    logic [LED_W-1:0]    r_led;

    rise_detect u_rise_up (
        .clk     (CLK_50),
        .rst     (reset),
        .i_level (pb_seq_up),
        .o_rise  (w_up_rise)
    );

    rise_detect u_rise_dn (
        .clk     (CLK_50),
        .rst     (reset),
        .i_level (pb_seq_dn),
        .o_rise  (w_dn_rise)
    );

    assign w_mode = mode_e'(mode);

    // Sequence change beats a mode change, which beats a tick; the losers are dropped.
    always_comb begin
        w_seq_nxt  = r_seq;
        w_step_nxt = r_step;
        w_dir_nxt  = r_dir_back;
        w_done_nxt = r_done;
        if (w_up_rise && !w_dn_rise) begin
            w_seq_nxt  = (r_seq == c_seq_last) ? '0 : r_seq + 1'b1;
            w_step_nxt = '0;
            w_dir_nxt  = 1'b0;
            w_done_nxt = 1'b0;
        end else if (!w_up_rise && w_dn_rise) begin
            w_seq_nxt  = (r_seq == '0) ? c_seq_last : r_seq - 1'b1;
            w_step_nxt = '0;
            w_dir_nxt  = 1'b0;
            w_done_nxt = 1'b0;
        end else if (w_mode != r_mode_prev) begin
            w_dir_nxt  = 1'b0;
            w_done_nxt = 1'b0;
        end else if (tick && !pause) begin
            case (w_mode)
                MODE_LOOP: begin
                    w_step_nxt = (r_step == c_step_last) ? '0 : r_step + 1'b1;
                end
                MODE_PINGPONG: begin
                    if (NUM_STEP > 1) begin
                        if (!r_dir_back) begin
                            if (r_step == c_step_last) begin
                                w_dir_nxt  = 1'b1;
                                w_step_nxt = c_step_pen;
                            end else begin
                                w_step_nxt = r_step + 1'b1;
                            end
                        end else begin
                            if (r_step == '0) begin
                                w_dir_nxt  = 1'b0;
                                w_step_nxt = STEP_W'(1);
                            end else begin
                                w_step_nxt = r_step - 1'b1;
                            end
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (r_step == c_step_last) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_upd = (w_seq_nxt != r_seq) || (w_step_nxt != r_step);

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_seq       <= '0;
            r_step      <= '0;
            r_dir_back  <= 1'b0;
            r_done      <= 1'b0;
            r_mode_prev <= w_mode;
            r_upd_pipe  <= '0;
            r_led       <= '0;
        end else begin
            r_seq       <= w_seq_nxt;
            r_step      <= w_step_nxt;
            r_dir_back  <= w_dir_nxt;
            r_done      <= w_done_nxt;
            r_mode_prev <= w_mode;
            r_upd_pipe  <= (r_upd_pipe << 1) | ROM_LAT'(w_upd);
            if (r_upd_pipe[ROM_LAT-1]) begin
                r_led <= rom_data;
            end
        end
    end

    assign rom_addr = {r_seq, r_step};
    assign led      = r_led;
    assign seq_num  = r_seq;
    assign step     = r_step;
    assign done     = r_done;

`ifdef PLAYER_HEX_EN
    logic [7:0] w_seq8;
    logic [6:0] r_hex1;
    logic [6:0] r_hex0;

    assign w_seq8 = 8'(r_seq);

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_hex1 <= HEX_BLANK;
            r_hex0 <= HEX_BLANK;
        end else begin
            r_hex1 <= seg7_lut(w_seq8[7:4]);
            r_hex0 <= seg7_lut(w_seq8[3:0]);
        end
    end

    assign hex1 = r_hex1;
    assign hex0 = r_hex0;
`else
    assign hex1 = HEX_BLANK;
    assign hex0 = HEX_BLANK;
`endif

endmodule

`default_nettype wire
